traffic_analyzer_gmii: RTL and testbench
========================================

Name: traffic_analyzer_gmii

Overview:
- GMII receive-side checker: the far end of the traffic generator link. Takes the byte stream from the DUT/loopback, finds preamble/SFD and checks the FCS.
- Extracts the 8-byte sequence number and 10-byte transmit timestamp that the generator places immediately before the FCS.
- Counts good, bad and lost frames and reports per-frame latency against the local sec/nsec clock.
- Sits beside traffic_generator_gmii in the tester core, driven by the same time base.

Parameters:
MIN_FRAME_LEN, 64, minimum legal length in bytes (after SFD, including FCS)
MAX_FRAME_LEN, 1518, maximum legal length in bytes (after SFD, including FCS)
LEN_WIDTH, 16, width of frame length fields

Ports:
clk  in  1  receive clock
resetn  in  1  synchronous active-low reset
gmii_d  in  8  GMII receive data
gmii_dv  in  1  GMII data valid
gmii_er  in  1  GMII receive error
sec  in  48  local time, seconds
nsec  in  30  local time, nanoseconds (0..999999999)
enable  in  1  analyzer run control; frames starting while low are ignored
clear  in  1  synchronous clear of counters and sequence tracking
frame_done  out  1  one-cycle pulse per frame evaluated
frame_len  out  LEN_WIDTH  length of last frame
seq_num  out  64  sequence number of last good frame
latency_ns  out  32  latency of last good frame
pkts_good  out  32  good-frame counter
pkts_crc_err  out  32  FCS-error counter
pkts_len_err  out  32  runt/giant/gmii_er counter
pkts_seq_err  out  32  sequence discontinuity counter

Behaviour:
- Reset (resetn=0 at a clk edge): every output is 0 and the FSM goes to IDLE.
- All registers are synchronous to clk.
- clear=1 zeroes all four counters and the seq_valid flag. When clear coincides with a frame evaluation, clear wins: counters go to 0, but frame_done/frame_len/seq_num still update.
- FSM states:
  - IDLE: on gmii_dv=1 with enable=1, go to PREAMBLE.
  - PREAMBLE: bytes 0x55 stay in PREAMBLE. Byte 0xD5 latches rx_sec/rx_nsec, initialises the CRC, zeroes the length, and goes to DATA. Any other byte, or gmii_dv=0, goes to DROP.
  - DATA: each valid byte feeds the CRC, increments the length (saturating at all-ones) and shifts into a 22-byte trailer shift register. gmii_er=1 sets an err flag. gmii_dv=0 goes to EVAL.
  - EVAL: one cycle. Pulses frame_done and classifies the frame (below). Goes to IDLE.
  - DROP: wait for gmii_dv=0, then go to IDLE. No counters change and no frame_done.
- enable falling mid-frame does not abort: the frame in progress completes. A new frame can start the cycle after EVAL; the GMII IFG guarantees this.
- Classification, in priority order:
  1. err, or length < MIN_FRAME_LEN, or length > MAX_FRAME_LEN: pkts_len_err++.
  2. Otherwise, CRC register not equal to residue 32'hDEBB20E3 (reflected IEEE 802.3 CRC-32, init 0xFFFFFFFF, run over all bytes including FCS): pkts_crc_err++.
  3. Otherwise the frame is good: pkts_good++.
- Counters wrap at 2^32.
- Trailer layout, oldest byte first (bytes -22..-5 relative to frame end):
  - seq[63:0], big-endian, 8 bytes.
  - tx_sec[47:0], 6 bytes.
  - 2'b00 followed by tx_nsec[29:0], 4 bytes.
- Sequence check (good frames only):
  - If seq_valid and seq != last_seq+1 (64-bit wrap), pkts_seq_err++.
  - Then last_seq <= seq, seq_valid <= 1, seq_num <= seq.
  - The first good frame after reset/clear never counts as a sequence error.
- Latency (good frames only):
  - rx_sec == tx_sec: latency_ns = rx_nsec - tx_nsec.
  - rx_sec == tx_sec+1: latency_ns = rx_nsec + 1000000000 - tx_nsec.
  - Any other case, or a negative result: latency_ns = 32'hFFFFFFFF.
- Latency is 0 cycles after the gmii_dv fall: frame_done and all outputs update in EVAL, one cycle after the first dv=0 sample.

Optional Feature:
- Macro: TRAFFIC_ANALYZER_TRAILER_EN.
- Defined: trailer shift register, sequence check and latency are built as described above.
- Undefined: none of those are built. seq_num, latency_ns and pkts_seq_err are tied to 0, and only length/FCS classification and counting remain.

Decomposition:
- Package traffic_analyzer_gmii_pkg holds:
  - state enum (IDLE, PREAMBLE, DATA, EVAL, DROP);
  - constants PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5, CRC_RESIDUE=32'hDEBB20E3, TRAILER_LEN=22, NS_PER_SEC=1000000000.
- One sub-module, crc32_rx_8: byte-wide reflected CRC-32 with init, d_valid and a residue_ok output. It is reused independently of the transmit-side CRC.

Test Plan:
- Reset with gmii_dv toggling -> all outputs 0, no frame_done.
- Generator-format 64-byte frame, seq=5, tx_sec=rx_sec, tx_nsec=1000, SFD seen at nsec=1500 -> pkts_good=1, seq_num=5, latency_ns=500, frame_len=64.
- Same frame with one FCS bit flipped -> pkts_crc_err=1, pkts_good unchanged, seq_num unchanged.
- Seq 5, 6, 8 consecutive good frames -> pkts_seq_err=1, pkts_good=3.
- 60-byte frame, and a 100-byte frame with gmii_er pulsed at byte 40 -> pkts_len_err=2.
- tx_sec=9, tx_nsec=999999900, rx_sec=10, rx_nsec=50 -> latency_ns=150.
- clear asserted during EVAL -> counters 0.
- Bad preamble byte 0x57 -> DROP, no frame_done.

Source files
------------

// File: rtl/traffic_analyzer_gmii_pkg.sv
// traffic_analyzer_gmii_pkg: shared states, constants and byte-wise CRC-32 step for the GMII analyzer
package traffic_analyzer_gmii_pkg;
    typedef enum logic [2:0] {IDLE, PREAMBLE, DATA, EVAL, DROP} state_t;
    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE = 8'hD5;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
    localparam int TRAILER_LEN = 22;
    localparam logic [31:0] NS_PER_SEC = 32'd1000000000;
    localparam logic [31:0] CRC_POLY = 32'hEDB88320;

    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ CRC_POLY : r >> 1;
        return r;
    endfunction
endpackage

// File: rtl/traffic_analyzer_gmii_crc32_rx_8.sv
// crc32_rx_8: byte-wide reflected CRC-32 accumulator flagging the IEEE 802.3 good-frame residue
module crc32_rx_8
    import traffic_analyzer_gmii_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       init,
    input  logic       d_valid,
    input  logic [7:0] d,
    output logic       residue_ok
);
    logic [31:0] crc;

    always_ff @(posedge clk) begin
        if (!resetn || init) crc <= '1;
        else if (d_valid) crc <= crc32_byte(crc, d);
    end

    assign residue_ok = crc == CRC_RESIDUE;
endmodule

// File: rtl/traffic_analyzer_gmii.sv
// traffic_analyzer_gmii: GMII rx checker (preamble/SFD, FCS, length); macro TRAFFIC_ANALYZER_TRAILER_EN adds seq/latency trailer checks
module traffic_analyzer_gmii
    import traffic_analyzer_gmii_pkg::*;
#(
    parameter int MIN_FRAME_LEN = 64,
    parameter int MAX_FRAME_LEN = 1518,
    parameter int LEN_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [7:0]           gmii_d,
    input  logic                 gmii_dv,
    input  logic                 gmii_er,
    input  logic [47:0]          sec,
    input  logic [29:0]          nsec,
    input  logic                 enable,
    input  logic                 clear,
    output logic                 frame_done,
    output logic [LEN_WIDTH-1:0] frame_len,
    output logic [63:0]          seq_num,
    output logic [31:0]          latency_ns,
    output logic [31:0]          pkts_good,
    output logic [31:0]          pkts_crc_err,
    output logic [31:0]          pkts_len_err,
    output logic [31:0]          pkts_seq_err
);
    state_t state, state_nx;
    logic [LEN_WIDTH-1:0] len;
    logic err, sfd, byte_en, eval, crc_ok, len_bad, good;

    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        sfd = 1'b0;
        byte_en = 1'b0;
        eval = 1'b0;
        case (state)
            IDLE: state_nx = (gmii_dv && enable) ? PREAMBLE : IDLE;
            PREAMBLE: begin
                sfd = gmii_dv && gmii_d == SFD_BYTE;
                state_nx = sfd ? DATA : (gmii_dv && gmii_d == PREAMBLE_BYTE) ? PREAMBLE : DROP;
            end
            DATA: begin
                byte_en = gmii_dv;
                eval = !gmii_dv;
                state_nx = gmii_dv ? DATA : EVAL;
            end
            EVAL: state_nx = IDLE;
            DROP: state_nx = gmii_dv ? DROP : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    crc32_rx_8 u_crc (
        .clk(clk),
        .resetn(resetn),
        .init(sfd),
        .d_valid(byte_en),
        .d(gmii_d),
        .residue_ok(crc_ok)
    );

    // Classification is registered on entry to EVAL so every output is valid while frame_done is high
    assign frame_done = state == EVAL;
    assign len_bad = err || len < LEN_WIDTH'(MIN_FRAME_LEN) || len > LEN_WIDTH'(MAX_FRAME_LEN);
    assign good = eval && !len_bad && crc_ok;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            len <= '0;
            err <= 1'b0;
        end else if (sfd) begin
            len <= '0;
            err <= 1'b0;
        end else if (byte_en) begin
            len <= &len ? len : len + 1'b1;
            err <= err | gmii_er;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            frame_len <= '0;
            pkts_good <= '0;
            pkts_crc_err <= '0;
            pkts_len_err <= '0;
        end else begin
            if (eval) frame_len <= len;
            if (clear) begin
                pkts_good <= '0;
                pkts_crc_err <= '0;
                pkts_len_err <= '0;
            end else if (eval) begin
                if (len_bad) pkts_len_err <= pkts_len_err + 32'd1;
                else if (!crc_ok) pkts_crc_err <= pkts_crc_err + 32'd1;
                else pkts_good <= pkts_good + 32'd1;
            end
        end
    end

`ifdef TRAFFIC_ANALYZER_TRAILER_EN
    logic [TRAILER_LEN*8-1:0] trailer;
    logic [63:0] seq_rx, last_seq;
    logic [47:0] rx_sec, tx_sec;
    logic [29:0] rx_nsec, tx_nsec;
    logic [32:0] lat_same, lat_next;
    logic [31:0] lat;
    logic seq_valid, unused_trailer;

    // Trailer holds the last 22 bytes: seq, tx_sec, tx_nsec word, FCS (oldest at the top)
    assign seq_rx = trailer[175:112];
    assign tx_sec = trailer[111:64];
    assign tx_nsec = trailer[61:32];
    assign unused_trailer = ^{trailer[63:62], trailer[31:0]};
    assign lat_same = {3'b0, rx_nsec} - {3'b0, tx_nsec};
    assign lat_next = {3'b0, rx_nsec} + {1'b0, NS_PER_SEC} - {3'b0, tx_nsec};

    always_comb begin
        lat = rx_sec == tx_sec ? (lat_same[32] ? '1 : lat_same[31:0]) :
              rx_sec == tx_sec + 48'd1 ? (lat_next[32] ? '1 : lat_next[31:0]) : '1;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            trailer <= '0;
            rx_sec <= '0;
            rx_nsec <= '0;
            last_seq <= '0;
            seq_valid <= 1'b0;
            seq_num <= '0;
            latency_ns <= '0;
            pkts_seq_err <= '0;
        end else begin
            if (sfd) begin
                rx_sec <= sec;
                rx_nsec <= nsec;
            end
            if (byte_en) trailer <= {trailer[TRAILER_LEN*8-9:0], gmii_d};
            if (good) begin
                seq_num <= seq_rx;
                latency_ns <= lat;
                last_seq <= seq_rx;
            end
            if (clear) begin
                pkts_seq_err <= '0;
                seq_valid <= 1'b0;
            end else if (good) begin
                seq_valid <= 1'b1;
                if (seq_valid && seq_rx != last_seq + 64'd1) pkts_seq_err <= pkts_seq_err + 32'd1;
            end
        end
    end
`else
    logic unused_time;
    assign unused_time = ^{sec, nsec, good};
    assign seq_num = '0;
    assign latency_ns = '0;
    assign pkts_seq_err = '0;
`endif
endmodule

// File: tb/tb_traffic_analyzer_gmii.sv
// tb_traffic_analyzer_gmii: directed checks of framing, FCS, length, sequence, latency and clear
module tb_traffic_analyzer_gmii;
`ifdef TRAFFIC_ANALYZER_TRAILER_EN
    localparam bit TR = 1'b1;
`else
    localparam bit TR = 1'b0;
`endif
    logic clk = 1'b0, resetn = 1'b0;
    logic [7:0] gmii_d = '0;
    logic gmii_dv = 1'b0, gmii_er = 1'b0, enable = 1'b1, clear = 1'b0;
    logic [47:0] sec = '0;
    logic [29:0] nsec = '0;
    logic frame_done;
    logic [15:0] frame_len;
    logic [63:0] seq_num;
    logic [31:0] latency_ns, pkts_good, pkts_crc_err, pkts_len_err, pkts_seq_err;
    logic [7:0] fb [0:1599];
    int errors = 0, checks = 0;
    int done_at, pulses;

    traffic_analyzer_gmii dut (
        .clk(clk), .resetn(resetn), .gmii_d(gmii_d), .gmii_dv(gmii_dv), .gmii_er(gmii_er),
        .sec(sec), .nsec(nsec), .enable(enable), .clear(clear), .frame_done(frame_done),
        .frame_len(frame_len), .seq_num(seq_num), .latency_ns(latency_ns), .pkts_good(pkts_good),
        .pkts_crc_err(pkts_crc_err), .pkts_len_err(pkts_len_err), .pkts_seq_err(pkts_seq_err)
    );

    always #5 clk = ~clk;

    // Builds a generator-format frame (trailer + FCS) and sends it with preamble/SFD
    task automatic run_frame(input int n, input logic [63:0] seq, input logic [47:0] txs,
                             input logic [29:0] txn, input bit flip, input int er_at,
                             input bit clr, input logic [7:0] pre3);
        logic [31:0] c, w;
        logic fbit;
        w = {2'b00, txn};
        for (int i = 0; i < n; i++) fb[i] = i[7:0] ^ 8'hA5;
        for (int i = 0; i < 8; i++) fb[n-22+i] = seq[63-8*i -: 8];
        for (int i = 0; i < 6; i++) fb[n-14+i] = txs[47-8*i -: 8];
        for (int i = 0; i < 4; i++) fb[n-8+i] = w[31-8*i -: 8];
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n - 4; i++)
            for (int j = 0; j < 8; j++) begin
                fbit = c[0] ^ fb[i][j];
                c = c >> 1;
                if (fbit) c = c ^ 32'hEDB88320;
            end
        c = ~c;
        for (int k = 0; k < 4; k++) fb[n-4+k] = c[8*k +: 8];
        if (flip) fb[n-1][3] = ~fb[n-1][3];
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            gmii_dv = 1'b1;
            gmii_d = i == 7 ? 8'hD5 : i == 2 ? pre3 : 8'h55;
        end
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            gmii_d = fb[i];
            gmii_er = i == er_at;
        end
        @(negedge clk);
        gmii_dv = 1'b0;
        gmii_er = 1'b0;
        gmii_d = '0;
        clear = clr;
        done_at = -1;
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            clear = 1'b0;
            if (frame_done) begin
                pulses++;
                if (done_at < 0) done_at = k;
            end
        end
    endtask

    task automatic test_reset();
        bit seen = 1'b0;
        resetn = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            gmii_dv = ~gmii_dv;
            gmii_d = 8'h55;
            if (frame_done) seen = 1'b1;
        end
        gmii_dv = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL reset_done got %0d exp 0", seen); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %0d exp 0", frame_done); end
        checks++; if (frame_len !== 16'd0) begin errors++; $display("FAIL reset_len got %0d exp 0", frame_len); end
        checks++; if (seq_num !== 64'd0) begin errors++; $display("FAIL reset_seq got %0d exp 0", seq_num); end
        checks++; if (latency_ns !== 32'd0) begin errors++; $display("FAIL reset_lat got %0d exp 0", latency_ns); end
        checks++; if ({pkts_good, pkts_crc_err, pkts_len_err, pkts_seq_err} !== 128'd0) begin
            errors++; $display("FAIL reset_counters got %0d/%0d/%0d/%0d exp 0", pkts_good, pkts_crc_err, pkts_len_err, pkts_seq_err);
        end
    endtask

    task automatic test_good();
        sec = 48'd100;
        nsec = 30'd1500;
        run_frame(64, 64'd5, 48'd100, 30'd1000, 1'b0, -1, 1'b0, 8'h55);
        checks++; if (done_at !== 0) begin errors++; $display("FAIL good_done_at got %0d exp 0", done_at); end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL good_pulses got %0d exp 1", pulses); end
        checks++; if (pkts_good !== 32'd1) begin errors++; $display("FAIL good_count got %0d exp 1", pkts_good); end
        checks++; if (frame_len !== 16'd64) begin errors++; $display("FAIL good_len got %0d exp 64", frame_len); end
        checks++; if (seq_num !== (TR ? 64'd5 : 64'd0)) begin errors++; $display("FAIL good_seq got %0d exp %0d", seq_num, TR ? 5 : 0); end
        checks++; if (latency_ns !== (TR ? 32'd500 : 32'd0)) begin errors++; $display("FAIL good_lat got %0d exp %0d", latency_ns, TR ? 500 : 0); end
        checks++; if (pkts_crc_err !== 32'd0 || pkts_len_err !== 32'd0) begin
            errors++; $display("FAIL good_err_counts got %0d/%0d exp 0/0", pkts_crc_err, pkts_len_err);
        end
    endtask

    task automatic test_crc_err();
        run_frame(64, 64'd77, 48'd100, 30'd1000, 1'b1, -1, 1'b0, 8'h55);
        checks++; if (pkts_crc_err !== 32'd1) begin errors++; $display("FAIL crc_count got %0d exp 1", pkts_crc_err); end
        checks++; if (pkts_good !== 32'd1) begin errors++; $display("FAIL crc_good got %0d exp 1", pkts_good); end
        checks++; if (seq_num !== (TR ? 64'd5 : 64'd0)) begin errors++; $display("FAIL crc_seq got %0d exp %0d", seq_num, TR ? 5 : 0); end
    endtask

    task automatic test_seq();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        checks++; if (pkts_good !== 32'd0 || pkts_crc_err !== 32'd0) begin
            errors++; $display("FAIL clear_counts got %0d/%0d exp 0/0", pkts_good, pkts_crc_err);
        end
        run_frame(64, 64'd5, 48'd100, 30'd1000, 1'b0, -1, 1'b0, 8'h55);
        run_frame(64, 64'd6, 48'd100, 30'd1000, 1'b0, -1, 1'b0, 8'h55);
        run_frame(64, 64'd8, 48'd100, 30'd1000, 1'b0, -1, 1'b0, 8'h55);
        checks++; if (pkts_good !== 32'd3) begin errors++; $display("FAIL seq_good got %0d exp 3", pkts_good); end
        checks++; if (pkts_seq_err !== (TR ? 32'd1 : 32'd0)) begin errors++; $display("FAIL seq_err got %0d exp %0d", pkts_seq_err, TR ? 1 : 0); end
        checks++; if (seq_num !== (TR ? 64'd8 : 64'd0)) begin errors++; $display("FAIL seq_last got %0d exp %0d", seq_num, TR ? 8 : 0); end
    endtask

    task automatic test_len();
        run_frame(60, 64'd99, 48'd100, 30'd1000, 1'b0, -1, 1'b0, 8'h55);
        checks++; if (pkts_len_err !== 32'd1) begin errors++; $display("FAIL runt_count got %0d exp 1", pkts_len_err); end
        checks++; if (frame_len !== 16'd60) begin errors++; $display("FAIL runt_len got %0d exp 60", frame_len); end
        run_frame(100, 64'd99, 48'd100, 30'd1000, 1'b0, 40, 1'b0, 8'h55);
        checks++; if (pkts_len_err !== 32'd2) begin errors++; $display("FAIL er_count got %0d exp 2", pkts_len_err); end
        checks++; if (frame_len !== 16'd100) begin errors++; $display("FAIL er_len got %0d exp 100", frame_len); end
        run_frame(1518, 64'd9, 48'd100, 30'd1000, 1'b0, -1, 1'b0, 8'h55);
        checks++; if (pkts_good !== 32'd4) begin errors++; $display("FAIL max_good got %0d exp 4", pkts_good); end
        run_frame(1519, 64'd99, 48'd100, 30'd1000, 1'b0, -1, 1'b0, 8'h55);
        checks++; if (pkts_len_err !== 32'd3) begin errors++; $display("FAIL giant_count got %0d exp 3", pkts_len_err); end
        checks++; if (pkts_good !== 32'd4 || pkts_crc_err !== 32'd0) begin
            errors++; $display("FAIL len_others got %0d/%0d exp 4/0", pkts_good, pkts_crc_err);
        end
    endtask

    task automatic test_latency();
        sec = 48'd10;
        nsec = 30'd50;
        run_frame(64, 64'd10, 48'd9, 30'd999999900, 1'b0, -1, 1'b0, 8'h55);
        checks++; if (latency_ns !== (TR ? 32'd150 : 32'd0)) begin errors++; $display("FAIL lat_wrap got %0d exp %0d", latency_ns, TR ? 150 : 0); end
        checks++; if (pkts_good !== 32'd5) begin errors++; $display("FAIL lat_good got %0d exp 5", pkts_good); end
        sec = 48'd100;
        nsec = 30'd1500;
        run_frame(64, 64'd11, 48'd100, 30'd2000, 1'b0, -1, 1'b0, 8'h55);
        checks++; if (latency_ns !== (TR ? 32'hFFFFFFFF : 32'd0)) begin errors++; $display("FAIL lat_neg got %h exp %h", latency_ns, TR ? 32'hFFFFFFFF : 32'd0); end
        checks++; if (pkts_seq_err !== (TR ? 32'd1 : 32'd0)) begin errors++; $display("FAIL lat_seq_err got %0d exp %0d", pkts_seq_err, TR ? 1 : 0); end
    endtask

    task automatic test_clear_eval();
        run_frame(64, 64'd12, 48'd100, 30'd1000, 1'b0, -1, 1'b1, 8'h55);
        checks++; if (done_at !== 0) begin errors++; $display("FAIL clr_done_at got %0d exp 0", done_at); end
        checks++; if ({pkts_good, pkts_crc_err, pkts_len_err, pkts_seq_err} !== 128'd0) begin
            errors++; $display("FAIL clr_counters got %0d/%0d/%0d/%0d exp 0", pkts_good, pkts_crc_err, pkts_len_err, pkts_seq_err);
        end
        checks++; if (seq_num !== (TR ? 64'd12 : 64'd0)) begin errors++; $display("FAIL clr_seq got %0d exp %0d", seq_num, TR ? 12 : 0); end
        run_frame(64, 64'd50, 48'd100, 30'd1000, 1'b0, -1, 1'b0, 8'h55);
        checks++; if (pkts_good !== 32'd1 || pkts_seq_err !== 32'd0) begin
            errors++; $display("FAIL clr_restart got %0d/%0d exp 1/0", pkts_good, pkts_seq_err);
        end
    endtask

    task automatic test_drop();
        run_frame(64, 64'd51, 48'd100, 30'd1000, 1'b0, -1, 1'b0, 8'h57);
        checks++; if (done_at !== -1) begin errors++; $display("FAIL badpre_done got %0d exp -1", done_at); end
        checks++; if (pkts_good !== 32'd1 || pkts_len_err !== 32'd0 || pkts_crc_err !== 32'd0) begin
            errors++; $display("FAIL badpre_counts got %0d/%0d/%0d exp 1/0/0", pkts_good, pkts_len_err, pkts_crc_err);
        end
        enable = 1'b0;
        run_frame(64, 64'd51, 48'd100, 30'd1000, 1'b0, -1, 1'b0, 8'h55);
        enable = 1'b1;
        checks++; if (done_at !== -1 || pkts_good !== 32'd1) begin
            errors++; $display("FAIL disabled got done_at=%0d good=%0d exp -1/1", done_at, pkts_good);
        end
    endtask

    initial begin
        test_reset();
        test_good();
        test_crc_err();
        test_seq();
        test_len();
        test_latency();
        test_clear_eval();
        test_drop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
